// File: rtl/byte_serial_tx.sv
// byte_serial_tx
//   Parallel-to-serial word transmitter. A word is taken over a load
//   valid/ready handshake and sent out one bit per accepted beat,
//   MSB-first (dir=0) or LSB-first (dir=1). Sends into the serial-in
//   (SL/SR) of the downstream shifter.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   din, dir          parallel word and bit order, sampled on load handshake
//   load_valid/ready  load handshake (ready only while idle)
//   sout, sout_valid  serial bit and its qualifier
//   sout_ready        downstream accepts sout this cycle
//   sout_last         current beat is the final bit of the word
//   done              one-cycle pulse after the final beat is accepted
//   busy              word in flight (same as sout_valid)
//
// All outputs decode from flops only; sout_ready and load_valid have no
// combinational path to any output.
module byte_serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic             ord;   // latched bit order for the word in flight
  logic [CW-1:0]    cnt;   // beats remaining after the current one

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      ord   <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            sreg  <= din;
            ord   <= dir;
            cnt   <= CW'(WIDTH - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sout_ready) begin
            if (cnt != '0) begin
              // Move the next bit toward the emitted end, zero-fill.
              if (ord) sreg <= {1'b0, sreg[WIDTH-1:1]};
              else     sreg <= {sreg[WIDTH-2:0], 1'b0};
              cnt <= cnt - CW'(1);
            end else begin
              // Last beat: leave sreg/cnt alone, they are masked in IDLE.
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_ready = (state == IDLE);
  assign sout_valid = (state == SHIFT);
  assign busy       = sout_valid;
  // Masked by state so stale sreg/cnt never leak while idle.
  assign sout       = sout_valid & (ord ? sreg[0] : sreg[WIDTH-1]);
  assign sout_last  = sout_valid & (cnt == '0);

endmodule

// File: tb/tb_byte_serial_tx.sv
module tb_byte_serial_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         dir;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         sout_last;
  logic         done;
  logic         busy;

  int total = 0;
  int bad   = 0;

  byte_serial_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dir(dir),
    .load_valid(load_valid), .load_ready(load_ready),
    .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready),
    .sout_last(sout_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk8(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_ready"}, load_ready, 1'b1);
    chk1({tag, "_valid"}, sout_valid, 1'b0);
    chk1({tag, "_sout"},  sout,       1'b0);
    chk1({tag, "_last"},  sout_last,  1'b0);
    chk1({tag, "_busy"},  busy,       1'b0);
  endtask

  // Sends one word starting at the current negedge (must be idle) and
  // returns at the negedge of the done cycle. Expected bit k is simply
  // d[W-1-k] (MSB-first) or d[k] (LSB-first); a downstream shifter model
  // rebuilds the word from accepted beats.
  //   rnd      : random sout_ready
  //   stall_at : beat index held off for stall_len cycles (-1 none)
  //   scr      : scramble din/dir while shifting
  //   chain    : hold load_valid with nd during the shift
  task automatic word(input string tag, input logic [W-1:0] d, input logic dr,
                      input bit rnd, input int stall_at, input int stall_len,
                      input bit scr, input bit chain, input logic [W-1:0] nd);
    int i = 0;
    int stalled = 0;
    int guard = 0;
    logic rdy;
    logic [W-1:0] rx = '0;
    chk1({tag, "_ld_rdy"}, load_ready, 1'b1);
    din = d; dir = dr; load_valid = 1'b1;
    @(negedge clk);
    load_valid = chain;
    if (chain) begin din = nd; dir = 1'b0; end
    while (i < W && guard < 400) begin
      chk1({tag, "_valid"}, sout_valid, 1'b1);
      chk1({tag, "_busy"},  busy,       1'b1);
      chk1({tag, "_ldrdy0"}, load_ready, 1'b0);
      chk1({tag, "_done0"}, done,       1'b0);
      chk1({tag, "_bit"},   sout,       dr ? d[i] : d[W-1-i]);
      chk1({tag, "_last"},  sout_last,  i == W-1);
      if (i == stall_at && stalled < stall_len) begin
        rdy = 1'b0; stalled++;
      end else if (rnd) rdy = ($urandom_range(0, 9) < 7);
      else rdy = 1'b1;
      sout_ready = rdy;
      if (rdy) rx = dr ? {sout, rx[W-1:1]} : {rx[W-2:0], sout};
      @(negedge clk);
      guard++;
      if (rdy) i++;
      if (scr && !chain) begin din = W'($urandom); dir = 1'($urandom); end
    end
    if (guard >= 400) begin
      bad++; total++;
      $display("FAIL %s_timeout observed=%0d expected<%0d", tag, guard, 400);
    end
    chk1({tag, "_done"},   done,       1'b1);
    chk1({tag, "_dn_rdy"}, load_ready, 1'b1);
    chk1({tag, "_dn_vld"}, sout_valid, 1'b0);
    chk1({tag, "_dn_sout"}, sout,      1'b0);
    chk8({tag, "_loop"},   rx,         d);
    if (stall_len > 0) chk1({tag, "_cyc"}, guard == W + stall_len, 1'b1);
  endtask

  initial begin
    logic [W-1:0] rd;
    rst_n = 1'b0; load_valid = 1'b0; din = '0; dir = 1'b0; sout_ready = 1'b0;
    #3;
    chk_idle("rst");
    chk1("rst_done", done, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("idle0");

    word("msb1e", 8'h1E, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk1("post_done0", done, 1'b0);
    chk_idle("post");

    word("lsb1e", 8'h1E, 1'b1, 1'b0, -1, 0, 1'b1, 1'b0, '0);
    @(negedge clk);

    // Stall during the 4th beat (bit 4 = 1) for 3 cycles: 8+3 cycles.
    word("stall", 8'hB4, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, '0);
    @(negedge clk);

    // Hold a pending load of FF through the shift of 00; FF is taken on
    // the done cycle, giving exactly one bubble.
    word("busy00", 8'h00, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1, 8'hFF);
    word("busyff", 8'hFF, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, '0);
    @(negedge clk);

    // Reset mid-word after 3 accepted beats of A5.
    din = 8'hA5; dir = 1'b0; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; sout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk1("mid_valid", sout_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    chk1("midrst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("midrst_nodone", done, 1'b0);
    chk_idle("midrel");
    word("after", 8'h0F, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, '0);
    @(negedge clk);

    word("lp00", 8'h00, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, '0);
    word("lpff", 8'hFF, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, '0);
    word("lp5a", 8'h5A, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, '0);
    word("lp81", 8'h81, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, '0);
    @(negedge clk);

    for (int n = 0; n < 25; n++) begin
      rd = W'($urandom);
      word("rand", rd, 1'($urandom), 1'b1, -1, 0, 1'b1, 1'b0, '0);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk1("rand_gap_done", done, 1'b0);
        chk_idle("rand_gap");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
